regfile_sb: RTL and testbench

Parametrised successor to the decode-stage register file. It provides a WIDTH x NREGS register file with NRD combinational read ports and one write port. Reads bypass a same-cycle write (write-first). A per-register pending-write scoreboard lets decode detect RAW hazards on long-latency results (loads, mult/div) and stall on them. The block sits in ID, and writeback drives it from ME.

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Decode-stage register file with write-first bypass and a per-register
// pending-write scoreboard (2-bit saturating counters) for RAW stall detection.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 wr_hold,
  input  logic                 wb_sb,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  output logic                 pending_any
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] rf       [NREGS];
  logic [1:0]       cnt      [NREGS];
  logic [1:0]       cnt_next [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic             any_next;
  logic             wr_en;

  assign wr_en     = we && !wr_hold && !(ZR && (wa == '0));
  assign iss_ready = iss_valid && (cnt[iss_addr] != 2'd3);

  // A decrement on an empty counter belongs to an op already squashed by flush.
  always_comb begin
    any_next = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = iss_ready && (iss_addr == AW'(r)) && !(ZR && (r == 0));
      dec[r] = wr_en && wb_sb && (wa == AW'(r)) && (cnt[r] != 2'd0);
      cnt_next[r] = cnt[r];
      if (flush)
        cnt_next[r] = 2'd0;
      else if (inc[r] && !dec[r])
        cnt_next[r] = cnt[r] + 2'd1;
      else if (dec[r] && !inc[r])
        cnt_next[r] = cnt[r] - 2'd1;
      any_next = any_next | (cnt_next[r] != 2'd0);
    end
  end

  // Last outstanding write arriving this cycle is served by the bypass, so no stall.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero_hit;
    assign ra       = rd_addr[i*AW +: AW];
    assign zero_hit = ZR && (ra == '0);
    assign rd_data[i*WIDTH +: WIDTH] = zero_hit                ? '0 :
                                       (wr_en && (wa == ra))   ? wd : rf[ra];
    assign rd_busy[i] = !zero_hit && (cnt[ra] != 2'd0) &&
                        !((cnt[ra] == 2'd1) && dec[ra]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        rf[r]  <= '0;
        cnt[r] <= 2'd0;
      end
      pending_any <= 1'b0;
    end else begin
      if (wr_en)
        rf[wa] <= wd;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= cnt_next[r];
      pending_any <= any_next;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb: one row per clock cycle,
// inputs driven after posedge and outputs compared mid-cycle.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, flush, we, wr_hold, wb_sb, iss_valid;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [4:0]  wa, iss_addr;
  logic [31:0] wd;
  logic        iss_ready, pending_any;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst, fl, we, hold, wbsb;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        iv;
    logic [4:0]  ia, a0, a1;
    logic [31:0] e0, e1;
    logic [1:0]  ebusy;
    logic        eready, epend;
  } vec_t;

  vec_t vecs[$];

  regfile_sb dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .wr_hold(wr_hold), .wb_sb(wb_sb),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic rst, logic fl, logic w, logic hold, logic sb,
                              logic [31:0] d, logic [4:0] a, logic iv, logic [4:0] ia,
                              logic [4:0] a0, logic [4:0] a1, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] eb, logic er, logic ep);
    vec_t v;
    v.name = n; v.rst = rst; v.fl = fl; v.we = w; v.hold = hold; v.wbsb = sb;
    v.wd = d; v.wa = a; v.iv = iv; v.ia = ia; v.a0 = a0; v.a1 = a1;
    v.e0 = e0; v.e1 = e1; v.ebusy = eb; v.eready = er; v.epend = ep;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; flush = v.fl; we = v.we; wr_hold = v.hold; wb_sb = v.wbsb;
    wd = v.wd; wa = v.wa; iss_valid = v.iv; iss_addr = v.ia;
    rd_addr = {v.a1, v.a0};
  endtask

  task automatic cmp(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h expected %h", tag, what, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    cmp(v.name, "rd_data0", rd_data[31:0], v.e0);
    cmp(v.name, "rd_data1", rd_data[63:32], v.e1);
    cmp(v.name, "rd_busy", {30'd0, rd_busy}, {30'd0, v.ebusy});
    cmp(v.name, "iss_ready", {31'd0, iss_ready}, {31'd0, v.eready});
    cmp(v.name, "pending_any", {31'd0, pending_any}, {31'd0, v.epend});
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name rst fl we hold sb wd wa iv ia a0 a1 | e0 e1 busy ready pend
    vecs.push_back(mk("reset_read", 0,0,0,0,0, 32'h0,        5'd0, 1,5'd0, 5'd5,5'd0, 32'h0,        32'h0,        2'b00,1,0));
    vecs.push_back(mk("wr_bypass",  0,0,1,0,0, 32'hDEADBEEF, 5'd5, 0,5'd0, 5'd5,5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00,0,0));
    vecs.push_back(mk("wr_visible", 0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd5,5'd0, 32'hDEADBEEF, 32'h0,        2'b00,0,0));
    vecs.push_back(mk("zero_wr",    0,0,1,0,0, 32'h1234,     5'd0, 1,5'd0, 5'd0,5'd5, 32'h0,        32'hDEADBEEF, 2'b00,1,0));
    vecs.push_back(mk("zero_after", 0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd0,5'd0, 32'h0,        32'h0,        2'b00,0,0));
    vecs.push_back(mk("iss_r3",     0,0,0,0,0, 32'h0,        5'd0, 1,5'd3, 5'd3,5'd5, 32'h0,        32'hDEADBEEF, 2'b00,1,0));
    vecs.push_back(mk("hold_wr",    0,0,1,1,1, 32'hAA,       5'd3, 0,5'd0, 5'd3,5'd3, 32'h0,        32'h0,        2'b11,0,1));
    vecs.push_back(mk("hold_after", 0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd3,5'd5, 32'h0,        32'hDEADBEEF, 2'b01,0,1));
    vecs.push_back(mk("wb_r3",      0,0,1,0,1, 32'hAA,       5'd3, 0,5'd0, 5'd3,5'd3, 32'hAA,       32'hAA,       2'b00,0,1));
    vecs.push_back(mk("r3_clear",   0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd3,5'd0, 32'hAA,       32'h0,        2'b00,0,0));
    vecs.push_back(mk("iss_r7",     0,0,0,0,0, 32'h0,        5'd0, 1,5'd7, 5'd7,5'd7, 32'h0,        32'h0,        2'b00,1,0));
    vecs.push_back(mk("use_r7",     0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd7,5'd3, 32'h0,        32'hAA,       2'b01,0,1));
    vecs.push_back(mk("wb_r7",      0,0,1,0,1, 32'h55,       5'd7, 0,5'd0, 5'd3,5'd7, 32'hAA,       32'h55,       2'b00,0,1));
    vecs.push_back(mk("r7_done",    0,0,0,0,0, 32'h0,        5'd0, 0,5'd0, 5'd7,5'd7, 32'h55,       32'h55,       2'b00,0,0));

    applyStimulus(mk("init", 1,0,0,0,0, 32'h0, 5'd0, 0,5'd0, 5'd0,5'd0, 32'h0,32'h0,2'b00,0,0));
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) runVec(vecs[i]);

    // Saturation on r9: a refused issue plus writeback drops to 2, the held issue refills to 3.
    runVec(mk("sat_iss1",  0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h0,  32'h0, 2'b00,1,0));
    runVec(mk("sat_iss2",  0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h0,  32'h0, 2'b01,1,1));
    runVec(mk("sat_iss3",  0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h0,  32'h0, 2'b01,1,1));
    runVec(mk("sat_full",  0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h0,  32'h0, 2'b01,0,1));
    runVec(mk("sat_wbiss", 0,0,1,0,1, 32'h99, 5'd9, 1,5'd9, 5'd9,5'd0, 32'h99, 32'h0, 2'b01,0,1));
    runVec(mk("sat_held",  0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h99, 32'h0, 2'b01,1,1));
    runVec(mk("sat_full2", 0,0,0,0,0, 32'h0,  5'd0, 1,5'd9, 5'd9,5'd0, 32'h99, 32'h0, 2'b01,0,1));
    runVec(mk("sat_wb1",   0,0,1,0,1, 32'hA1, 5'd9, 0,5'd0, 5'd9,5'd0, 32'hA1, 32'h0, 2'b01,0,1));
    runVec(mk("sat_wb2",   0,0,1,0,1, 32'hA2, 5'd9, 0,5'd0, 5'd9,5'd0, 32'hA2, 32'h0, 2'b01,0,1));
    runVec(mk("sat_wb3",   0,0,1,0,1, 32'hA3, 5'd9, 0,5'd0, 5'd9,5'd0, 32'hA3, 32'h0, 2'b00,0,1));
    runVec(mk("sat_done",  0,0,0,0,0, 32'h0,  5'd0, 0,5'd0, 5'd9,5'd0, 32'hA3, 32'h0, 2'b00,0,0));

    // Flush beats a same-cycle issue; the data write under flush still commits.
    runVec(mk("fl_iss4",   0,0,0,0,0, 32'h0,  5'd0, 1,5'd4, 5'd4,5'd6, 32'h0,  32'h0,  2'b00,1,0));
    runVec(mk("fl_iss6",   0,0,0,0,0, 32'h0,  5'd0, 1,5'd6, 5'd4,5'd6, 32'h0,  32'h0,  2'b01,1,1));
    runVec(mk("fl_flush",  0,1,1,0,0, 32'h66, 5'd6, 1,5'd4, 5'd4,5'd6, 32'h0,  32'h66, 2'b11,1,1));
    runVec(mk("fl_after",  0,0,0,0,0, 32'h0,  5'd0, 0,5'd0, 5'd4,5'd6, 32'h0,  32'h66, 2'b00,0,0));
    runVec(mk("fl_latewb", 0,0,1,0,1, 32'h44, 5'd4, 0,5'd0, 5'd4,5'd6, 32'h44, 32'h66, 2'b00,0,0));
    runVec(mk("fl_idle",   0,0,0,0,0, 32'h0,  5'd0, 0,5'd0, 5'd4,5'd6, 32'h44, 32'h66, 2'b00,0,0));

    // Reset mid-operation discards pending state and blocks the concurrent write.
    runVec(mk("rst_pend",  0,0,1,0,0, 32'h88, 5'd8, 1,5'd8, 5'd8,5'd0, 32'h88, 32'h0, 2'b00,1,0));
    runVec(mk("rst_mid",   1,0,1,0,0, 32'h77, 5'd2, 0,5'd0, 5'd8,5'd0, 32'h88, 32'h0, 2'b01,0,1));
    runVec(mk("rst_after", 0,0,0,0,0, 32'h0,  5'd0, 0,5'd0, 5'd8,5'd2, 32'h0,  32'h0, 2'b00,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
